tlb_translate_unit: RTL and testbench

Initiator side of the TLB search port: accepts virtual-address translation requests from a pipeline stage, drives `search_request_t` into the TLB, samples the returned `search_result_t`, and returns a physical address or a TLB exception code. A one-entry micro-TLB caches the last successful mapped translation so repeated accesses to the same page skip the TLB search. kseg0/kseg1 addresses bypass the TLB entirely. Sits between the fetch/memory stage and the `tlb_params`-based TLB array.

---
 rtl/tlb_translate_unit.sv | 234 +++++++++++++++++++++++
 tb/tb_tlb_translate_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_translate_unit.sv
// Initiator side of the TLB search port: kseg0/kseg1 bypass, a one-entry micro-TLB for the
// last mapped page, and a single-cycle TLB search for everything else.
package tlb_params;
   parameter int unsigned TLB_NUM = 16;
   parameter int unsigned IDX_W   = $clog2(TLB_NUM);

   typedef struct packed {
      logic [18:0] vpn2;
      logic        odd_page;
      logic [7:0]  asid;
   } search_request_t;

   typedef struct packed {
      logic [19:0] page_frame_number;
      logic [2:0]  cached;
      logic        is_dirty;
      logic        is_valid;
   } tlb_entry_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] index;
      tlb_entry_t       entry;
   } search_result_t;
endpackage

module tlb_translate_unit #(
   parameter int unsigned TLB_NUM = tlb_params::TLB_NUM
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [31:0]                    req_vaddr,
   input  logic                           req_is_store,
   input  logic [7:0]                     asid,
   input  logic                           tlb_write,
   output tlb_params::search_request_t    search_req,
   input  tlb_params::search_result_t     search_res,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output logic [31:0]                    resp_paddr,
   output logic [1:0]                     resp_exc,
   output logic [$clog2(TLB_NUM)-1:0]     resp_index,
   output logic [2:0]                     resp_cached
);

   localparam int unsigned IdxW = $clog2(TLB_NUM);

   localparam logic [1:0] ExcNone     = 2'b00;
   localparam logic [1:0] ExcRefill   = 2'b01;
   localparam logic [1:0] ExcInvalid  = 2'b10;
   localparam logic [1:0] ExcModified = 2'b11;

   typedef enum logic [1:0] {StIdle, StSearch, StResp} state_e;

   state_e            state_q, state_d;
   logic [31:0]       vaddr_q, vaddr_d;
   logic              is_store_q, is_store_d;

   logic              resp_valid_q, resp_valid_d;
   logic [31:0]       resp_paddr_q, resp_paddr_d;
   logic [1:0]        resp_exc_q, resp_exc_d;
   logic [IdxW-1:0]   resp_index_q, resp_index_d;
   logic [2:0]        resp_cached_q, resp_cached_d;

   logic              micro_valid_q, micro_valid_d;
   logic [18:0]       micro_vpn_q, micro_vpn_d;
   logic              micro_odd_q, micro_odd_d;
   logic [7:0]        micro_asid_q, micro_asid_d;
   logic [19:0]       micro_pfn_q, micro_pfn_d;
   logic [2:0]        micro_cached_q, micro_cached_d;
   logic              micro_dirty_q, micro_dirty_d;
   logic [IdxW-1:0]   micro_index_q, micro_index_d;

   logic              accept;
   logic              unmapped;
   logic              micro_hit;
   logic [1:0]        search_exc;

   assign req_ready = (state_q == StIdle);
   assign accept    = req_valid & req_ready;
   assign unmapped  = (req_vaddr[31:30] == 2'b10);

   // A TLB write in the same cycle may be rewriting the cached entry, so it vetoes the hit.
   assign micro_hit = micro_valid_q
                    & (micro_vpn_q == req_vaddr[31:13])
                    & (micro_odd_q == req_vaddr[12])
                    & (micro_asid_q == asid)
                    & ~tlb_write;

   assign search_req = '{vpn2: vaddr_q[31:13], odd_page: vaddr_q[12], asid: asid};

   assign resp_valid  = resp_valid_q;
   assign resp_paddr  = resp_paddr_q;
   assign resp_exc    = resp_exc_q;
   assign resp_index  = resp_index_q;
   assign resp_cached = resp_cached_q;

   always_comb begin
      search_exc = ExcNone;
      if (!search_res.found) begin
         search_exc = ExcRefill;
      end else if (!search_res.entry.is_valid) begin
         search_exc = ExcInvalid;
      end else if (is_store_q && !search_res.entry.is_dirty) begin
         search_exc = ExcModified;
      end
   end

   always_comb begin
      state_d        = state_q;
      vaddr_d        = vaddr_q;
      is_store_d     = is_store_q;
      resp_valid_d   = resp_valid_q;
      resp_paddr_d   = resp_paddr_q;
      resp_exc_d     = resp_exc_q;
      resp_index_d   = resp_index_q;
      resp_cached_d  = resp_cached_q;
      micro_valid_d  = micro_valid_q;
      micro_vpn_d    = micro_vpn_q;
      micro_odd_d    = micro_odd_q;
      micro_asid_d   = micro_asid_q;
      micro_pfn_d    = micro_pfn_q;
      micro_cached_d = micro_cached_q;
      micro_dirty_d  = micro_dirty_q;
      micro_index_d  = micro_index_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               vaddr_d    = req_vaddr;
               is_store_d = req_is_store;
               if (unmapped) begin
                  resp_paddr_d  = {3'b000, req_vaddr[28:0]};
                  resp_cached_d = req_vaddr[29] ? 3'd2 : 3'd3;
                  resp_exc_d    = ExcNone;
                  resp_index_d  = '0;
                  resp_valid_d  = 1'b1;
                  state_d       = StResp;
               end else if (micro_hit) begin
                  resp_paddr_d  = {micro_pfn_q, req_vaddr[11:0]};
                  resp_cached_d = micro_cached_q;
                  resp_exc_d    = (req_is_store && !micro_dirty_q) ? ExcModified : ExcNone;
                  resp_index_d  = micro_index_q;
                  resp_valid_d  = 1'b1;
                  state_d       = StResp;
               end else begin
                  state_d = StSearch;
               end
            end
         end
         StSearch: begin
            resp_paddr_d  = {search_res.entry.page_frame_number, vaddr_q[11:0]};
            resp_cached_d = search_res.entry.cached;
            resp_exc_d    = search_exc;
            resp_index_d  = IdxW'(search_res.index);
            resp_valid_d  = 1'b1;
            state_d       = StResp;
            if (search_res.found && search_res.entry.is_valid && !tlb_write) begin
               micro_valid_d  = 1'b1;
               micro_vpn_d    = vaddr_q[31:13];
               micro_odd_d    = vaddr_q[12];
               micro_asid_d   = asid;
               micro_pfn_d    = search_res.entry.page_frame_number;
               micro_cached_d = search_res.entry.cached;
               micro_dirty_d  = search_res.entry.is_dirty;
               micro_index_d  = IdxW'(search_res.index);
            end
         end
         StResp: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = StIdle;
            end
         end
         default: begin
            resp_valid_d = 1'b0;
            state_d      = StIdle;
         end
      endcase

      // Invalidation wins over a fill in the same cycle.
      if (tlb_write) begin
         micro_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         vaddr_q        <= '0;
         is_store_q     <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_paddr_q   <= '0;
         resp_exc_q     <= '0;
         resp_index_q   <= '0;
         resp_cached_q  <= '0;
         micro_valid_q  <= 1'b0;
         micro_vpn_q    <= '0;
         micro_odd_q    <= 1'b0;
         micro_asid_q   <= '0;
         micro_pfn_q    <= '0;
         micro_cached_q <= '0;
         micro_dirty_q  <= 1'b0;
         micro_index_q  <= '0;
      end else begin
         state_q        <= state_d;
         vaddr_q        <= vaddr_d;
         is_store_q     <= is_store_d;
         resp_valid_q   <= resp_valid_d;
         resp_paddr_q   <= resp_paddr_d;
         resp_exc_q     <= resp_exc_d;
         resp_index_q   <= resp_index_d;
         resp_cached_q  <= resp_cached_d;
         micro_valid_q  <= micro_valid_d;
         micro_vpn_q    <= micro_vpn_d;
         micro_odd_q    <= micro_odd_d;
         micro_asid_q   <= micro_asid_d;
         micro_pfn_q    <= micro_pfn_d;
         micro_cached_q <= micro_cached_d;
         micro_dirty_q  <= micro_dirty_d;
         micro_index_q  <= micro_index_d;
      end
   end

   resp_stall_stable_a: assert property (@(posedge clock) disable iff (!reset_n)
      (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_paddr) && $stable(resp_exc)
         && $stable(resp_index) && $stable(resp_cached)));

   resp_blocks_req_a: assert property (@(posedge clock) disable iff (!reset_n)
      resp_valid |-> !req_ready);

endmodule

// File: tb/tb_tlb_translate_unit.sv
// Directed bench for tlb_translate_unit: a driver queues expected responses, a negedge monitor
// pops and compares them, including accept-to-valid latency and stall stability.
module tb_tlb_translate_unit;

   logic                         clock = 1'b0;
   logic                         reset_n = 1'b0;
   logic                         req_valid = 1'b0;
   logic                         req_ready;
   logic [31:0]                  req_vaddr = '0;
   logic                         req_is_store = 1'b0;
   logic [7:0]                   asid = 8'h05;
   logic                         tlb_write = 1'b0;
   tlb_params::search_request_t  search_req;
   tlb_params::search_result_t   search_res;
   logic                         resp_valid;
   logic                         resp_ready = 1'b1;
   logic [31:0]                  resp_paddr;
   logic [1:0]                   resp_exc;
   logic [3:0]                   resp_index;
   logic [2:0]                   resp_cached;

   tlb_translate_unit #(.TLB_NUM(16)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_vaddr   (req_vaddr),
      .req_is_store(req_is_store),
      .asid        (asid),
      .tlb_write   (tlb_write),
      .search_req  (search_req),
      .search_res  (search_res),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_paddr  (resp_paddr),
      .resp_exc    (resp_exc),
      .resp_index  (resp_index),
      .resp_cached (resp_cached)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] paddr;
      logic [1:0]  exc;
      logic [3:0]  idx;
      logic [2:0]  cached;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_tlb(input logic found, input logic valid, input logic dirty,
                          input logic [19:0] pfn, input logic [3:0] idx, input logic [2:0] cached);
      search_res.found                   = found;
      search_res.index                   = idx;
      search_res.entry.is_valid          = valid;
      search_res.entry.is_dirty          = dirty;
      search_res.entry.page_frame_number = pfn;
      search_res.entry.cached            = cached;
   endtask

   // Issue one request, push its expected response, then wait for the monitor to consume it.
   task automatic issue(input logic [31:0] va, input logic st, input logic [31:0] paddr,
                        input logic [1:0] exc, input logic [3:0] idx, input logic [2:0] cached,
                        input int lat, input bit wr_search, input int hold);
      exp_t e;
      int   n;
      logic [27:0] exp_sreq;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      check("req_ready_idle", 32'(req_ready), 32'd1);
      req_vaddr    = va;
      req_is_store = st;
      req_valid    = 1'b1;
      if (hold > 0) resp_ready = 1'b0;
      @(posedge clock); #1;
      e.paddr   = paddr;
      e.exc     = exc;
      e.idx     = idx;
      e.cached  = cached;
      e.lat     = lat;
      e.acc_cyc = cyc;
      sb.push_back(e);
      req_valid = 1'b0;
      if (lat == 2) begin
         exp_sreq = {va[31:13], va[12], asid};
         check("search_req", 32'(search_req), 32'(exp_sreq));
      end
      if (wr_search) begin
         tlb_write = 1'b1;
         @(posedge clock); #1;
         tlb_write = 1'b0;
      end
      if (hold > 0) begin
         repeat (lat - 1 + hold - (wr_search ? 1 : 0)) @(posedge clock);
         #1;
         resp_ready = 1'b1;
      end
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL resp_timeout: got no response for vaddr 0x%0h, expected one", va);
         sb.delete();
      end
   endtask

   task automatic pulse_tlb_write();
      tlb_write = 1'b1;
      @(posedge clock); #1;
      tlb_write = 1'b0;
   endtask

   // Monitor
   initial begin
      bit          seen;
      int          first_cyc;
      logic [31:0] s_paddr;
      logic [1:0]  s_exc;
      logic [3:0]  s_idx;
      logic [2:0]  s_cached;
      exp_t        e;
      seen = 1'b0;
      first_cyc = 0;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            seen = 1'b0;
         end else if (resp_valid) begin
            if (!seen) begin
               seen      = 1'b1;
               first_cyc = cyc;
               s_paddr   = resp_paddr;
               s_exc     = resp_exc;
               s_idx     = resp_index;
               s_cached  = resp_cached;
            end else begin
               check("hold_paddr", resp_paddr, s_paddr);
               check("hold_exc", 32'(resp_exc), 32'(s_exc));
               check("hold_index", 32'(resp_index), 32'(s_idx));
               check("hold_cached", 32'(resp_cached), 32'(s_cached));
            end
            if (!resp_ready) begin
               check("req_ready_busy", 32'(req_ready), 32'd0);
            end else begin
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_resp: got paddr 0x%0h, expected no response",
                           resp_paddr);
               end else begin
                  e = sb.pop_front();
                  check("paddr", resp_paddr, e.paddr);
                  check("exc", 32'(resp_exc), 32'(e.exc));
                  check("index", 32'(resp_index), 32'(e.idx));
                  check("cached", 32'(resp_cached), 32'(e.cached));
                  check("latency", 32'(first_cyc - e.acc_cyc + 1), 32'(e.lat));
               end
               seen = 1'b0;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog");
   end

   // Stimulus
   initial begin
      logic [27:0] rst_sreq;
      set_tlb(1'b0, 1'b0, 1'b0, 20'h0, 4'd0, 3'd0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      rst_sreq = {19'b0, 1'b0, asid};
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_paddr", resp_paddr, 32'h0);
      check("rst_exc", 32'(resp_exc), 32'd0);
      check("rst_index", 32'(resp_index), 32'd0);
      check("rst_cached", 32'(resp_cached), 32'd0);
      check("rst_search_req", 32'(search_req), 32'(rst_sreq));

      // Unmapped kseg0 / kseg1
      issue(32'h8000_1234, 1'b0, 32'h0000_1234, 2'b00, 4'd0, 3'd3, 1, 1'b0, 0);
      issue(32'hA000_0010, 1'b0, 32'h0000_0010, 2'b00, 4'd0, 3'd2, 1, 1'b0, 0);

      // First mapped access searches and fills; same page then hits even with a useless TLB
      set_tlb(1'b1, 1'b1, 1'b1, 20'h12345, 4'd5, 3'd3);
      issue(32'h0040_0ABC, 1'b0, 32'h1234_5ABC, 2'b00, 4'd5, 3'd3, 2, 1'b0, 0);
      set_tlb(1'b0, 1'b0, 1'b0, 20'h0, 4'd0, 3'd0);
      issue(32'h0040_0123, 1'b0, 32'h1234_5123, 2'b00, 4'd5, 3'd3, 1, 1'b0, 0);

      // Odd page of the same pair misses: refill, no fill
      issue(32'h0040_1000, 1'b0, 32'h0000_0000, 2'b01, 4'd0, 3'd0, 2, 1'b0, 0);
      issue(32'h0040_0ABC, 1'b0, 32'h1234_5ABC, 2'b00, 4'd5, 3'd3, 1, 1'b0, 0);

      // Invalid entry
      set_tlb(1'b1, 1'b0, 1'b0, 20'h0ABCD, 4'd7, 3'd2);
      issue(32'h1000_2000, 1'b0, 32'h0ABC_D000, 2'b10, 4'd7, 3'd2, 2, 1'b0, 0);

      // Store to clean page: modified via search, then via micro hit; load is fine
      set_tlb(1'b1, 1'b1, 1'b0, 20'h00077, 4'd9, 3'd3);
      issue(32'h0050_0010, 1'b1, 32'h0007_7010, 2'b11, 4'd9, 3'd3, 2, 1'b0, 0);
      set_tlb(1'b0, 1'b0, 1'b0, 20'h0, 4'd0, 3'd0);
      issue(32'h0050_0FF0, 1'b1, 32'h0007_7FF0, 2'b11, 4'd9, 3'd3, 1, 1'b0, 0);
      issue(32'h0050_0004, 1'b0, 32'h0007_7004, 2'b00, 4'd9, 3'd3, 1, 1'b0, 0);

      // tlb_write while idle invalidates the micro entry
      pulse_tlb_write();
      set_tlb(1'b1, 1'b1, 1'b0, 20'h00077, 4'd9, 3'd3);
      issue(32'h0050_0004, 1'b0, 32'h0007_7004, 2'b00, 4'd9, 3'd3, 2, 1'b0, 0);
      set_tlb(1'b0, 1'b0, 1'b0, 20'h0, 4'd0, 3'd0);
      issue(32'h0050_0008, 1'b0, 32'h0007_7008, 2'b00, 4'd9, 3'd3, 1, 1'b0, 0);

      // tlb_write during SEARCH: response still correct, no fill
      set_tlb(1'b1, 1'b1, 1'b1, 20'h12345, 4'd5, 3'd3);
      issue(32'h0040_0ABC, 1'b0, 32'h1234_5ABC, 2'b00, 4'd5, 3'd3, 2, 1'b1, 0);
      issue(32'h0040_0ABC, 1'b0, 32'h1234_5ABC, 2'b00, 4'd5, 3'd3, 2, 1'b0, 0);

      // Stall the response for 4 cycles
      issue(32'h0040_0100, 1'b0, 32'h1234_5100, 2'b00, 4'd5, 3'd3, 1, 1'b0, 4);

      // ASID change forces a search
      asid = 8'h06;
      issue(32'h0040_0100, 1'b0, 32'h1234_5100, 2'b00, 4'd5, 3'd3, 2, 1'b0, 0);

      // Reset in the middle of SEARCH drops the request
      asid         = 8'h07;
      req_vaddr    = 32'h0060_0000;
      req_is_store = 1'b0;
      req_valid    = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      reset_n   = 1'b0;
      #1;
      rst_sreq = {19'b0, 1'b0, asid};
      check("midrst_resp_valid", 32'(resp_valid), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd1);
      check("midrst_search_req", 32'(search_req), 32'(rst_sreq));
      @(posedge clock); #1;
      reset_n = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      check("midrst_no_resp", 32'(resp_valid), 32'd0);

      // Micro entry was lost with the reset
      asid = 8'h06;
      issue(32'h0040_0100, 1'b0, 32'h1234_5100, 2'b00, 4'd5, 3'd3, 2, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
